// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, instruction field positions and encoder FSM state type,
// shared by the encoder and the decoder.
package isa_pkg;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_LW   = 6'd4;
  localparam logic [5:0] OP_SW   = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_OR   = 6'd7;
  localparam logic [5:0] OP_NOR  = 6'd8;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_BNE  = 6'd10;
  localparam logic [5:0] OP_SLT  = 6'd11;
  localparam logic [5:0] OP_EOF  = 6'd12;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam logic [31:0] EOF_WORD = {OP_EOF, 26'b0};
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field-to-word formatting and opcode legality check.
module instr_pack
  import isa_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic        is_eof
);
  logic r_type, i_type;
  logic [31:0] base;
  always_comb begin
    r_type = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT};
    i_type = opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
    is_eof = opcode == OP_EOF;
    legal = r_type || i_type || is_eof;
    base = (32'(opcode) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB);
    word = r_type ? base | (32'(rd) << RD_LSB) :
           i_type ? base | (32'(imm) << IMM_LSB) :
           is_eof ? EOF_WORD : '0;
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs instruction fields into words and writes them to instruction memory.
// Define ENCODER_CHECKSUM_EN to add a running XOR checksum output.
module instruction_encoder
  import isa_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err_opcode,
  output logic        err_full,
  output logic [8:0]  word_count
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  state_t state, next_state;
  logic [31:0] word, wr_word;
  logic legal, is_eof, xfer, clr, at_last, trunc;
  instr_pack u_pack (
    .opcode(in_opcode),
    .rs(in_rs),
    .rt(in_rt),
    .rd(in_rd),
    .imm(in_imm),
    .word(word),
    .legal(legal),
    .is_eof(is_eof)
  );
  always_comb begin
    in_ready = state == LOAD;
    xfer = in_valid && in_ready;
    clr = start && state != LOAD;
    at_last = word_count == DEPTH_W - 9'd1;
    trunc = at_last && !is_eof;
    wr_word = trunc ? EOF_WORD : word;
    next_state = clr ? LOAD : (xfer && legal && (is_eof || at_last)) ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= '0;
      done <= 1'b0;
      err_opcode <= 1'b0;
      err_full <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= xfer && legal;
      if (clr) begin
        mem_addr <= BASE_ADDR;
        done <= 1'b0;
        err_opcode <= 1'b0;
        err_full <= 1'b0;
        word_count <= '0;
      end else begin
        if (state == DONE) done <= 1'b1;
        if (xfer && !legal) err_opcode <= 1'b1;
        if (xfer && legal) begin
          mem_addr <= BASE_ADDR + {21'b0, word_count, 2'b00};
          mem_wdata <= wr_word;
          word_count <= word_count == DEPTH_W ? word_count : word_count + 9'd1;
          if (trunc) err_full <= 1'b1;
        end
      end
    end
`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) checksum <= '0;
    else if (clr) checksum <= '0;
    else if (xfer && legal) checksum <= checksum ^ wr_word;
`endif
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and random programs checked against a program-level reference model.
module tb_instruction_encoder;
  typedef struct {int op; int rs; int rt; int rd; int imm;} ins_t;
  logic clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [5:0] in_opcode = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic in_ready, mem_we, done, err_opcode, err_full;
  logic [31:0] mem_addr, mem_wdata;
  logic [8:0] word_count;
  logic d4_in_ready, d4_mem_we, d4_done, d4_err_opcode, d4_err_full;
  logic [31:0] d4_mem_addr, d4_mem_wdata;
  logic [8:0] d4_word_count;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] checksum, d4_checksum;
`endif
  int cmp = 0, bad = 0;
  ins_t prog[$];
  logic [31:0] got_a[$], got_w[$], got4_a[$], got4_w[$];
  logic [31:0] m_a[$], m_w[$];
  logic [31:0] m_chk;
  bit m_eo, m_ef, m_done;
  int m_cnt;

  always #5 clk = ~clk;

  instruction_encoder #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .err_opcode(err_opcode), .err_full(err_full), .word_count(word_count)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  instruction_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .done(d4_done),
    .err_opcode(d4_err_opcode), .err_full(d4_err_full), .word_count(d4_word_count)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum(d4_checksum)
`endif
  );

  always @(negedge clk) begin
    if (mem_we) begin got_a.push_back(mem_addr); got_w.push_back(mem_wdata); end
    if (d4_mem_we) begin got4_a.push_back(d4_mem_addr); got4_w.push_back(d4_mem_wdata); end
  end

  function automatic bit is_legal(input int op);
    return (op >= 1 && op <= 12);
  endfunction

  function automatic logic [31:0] enc(input ins_t i);
    if (i.op inside {1, 2, 6, 7, 8, 11})
      return 32'(i.op * (2 ** 26) + i.rs * (2 ** 21) + i.rt * (2 ** 16) + i.rd * (2 ** 11));
    if (i.op inside {3, 4, 5, 9, 10})
      return 32'(i.op * (2 ** 26) + i.rs * (2 ** 21) + i.rt * (2 ** 16) + i.imm);
    return 32'h3000_0000;
  endfunction

  task automatic model(input int d);
    logic [31:0] w;
    m_a.delete(); m_w.delete();
    m_eo = 0; m_ef = 0; m_done = 0; m_cnt = 0; m_chk = 0;
    foreach (prog[i]) begin
      if (m_done) break;
      if (!is_legal(prog[i].op)) begin m_eo = 1; continue; end
      if (m_cnt == d - 1 && prog[i].op != 12) begin
        w = 32'h3000_0000; m_ef = 1; m_done = 1;
      end else begin
        w = enc(prog[i]); m_done = prog[i].op == 12;
      end
      m_a.push_back(32'(4 * m_cnt)); m_w.push_back(w); m_chk ^= w; m_cnt++;
    end
  endtask

  task automatic clear_q;
    got_a.delete(); got_w.delete(); got4_a.delete(); got4_w.delete();
  endtask

  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input ins_t i);
    in_opcode = 6'(i.op); in_rs = 5'(i.rs); in_rt = 5'(i.rt); in_rd = 5'(i.rd); in_imm = 16'(i.imm);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run_prog;
    pulse_start();
    clear_q();
    foreach (prog[i]) send(prog[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    cmp++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    cmp++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    cmp++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    cmp++; if ({done, err_opcode, err_full} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {done, err_opcode, err_full}); end
    cmp++; if (word_count !== 9'd0) begin bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_add;
    pulse_start();
    cmp++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
    clear_q();
    send('{1, 1, 2, 3, 0});
    cmp++; if (mem_we !== 1'b1) begin bad++; $display("FAIL add_we: got %b want 1", mem_we); end
    cmp++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL add_addr: got %h want 0", mem_addr); end
    cmp++; if (mem_wdata !== 32'h0422_1800) begin bad++; $display("FAIL add_wdata: got %h want 04221800", mem_wdata); end
    @(negedge clk);
    cmp++; if (mem_we !== 1'b0) begin bad++; $display("FAIL add_we_pulse: got %b want 0", mem_we); end
    pulse_start();
    cmp++; if (word_count !== 9'd1) begin bad++; $display("FAIL start_in_load: got %0d want 1", word_count); end
    send('{12, 0, 0, 0, 0});
    cmp++; if (mem_wdata !== 32'h3000_0000 || mem_addr !== 32'h4) begin bad++; $display("FAIL eof_word: got %h@%h want 30000000@4", mem_wdata, mem_addr); end
    cmp++; if (done !== 1'b0) begin bad++; $display("FAIL done_early: got %b want 0", done); end
    @(negedge clk);
    cmp++; if (done !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL done_late: got done=%b rdy=%b want 1,0", done, in_ready); end
    cmp++; if (word_count !== 9'd2) begin bad++; $display("FAIL eof_count: got %0d want 2", word_count); end
  endtask

  task automatic test_imm;
    prog.delete();
    prog.push_back('{3, 0, 4, 0, 16'h0010});
    prog.push_back('{9, 1, 2, 0, 16'hFFFE});
    prog.push_back('{12, 0, 0, 0, 0});
    run_prog();
    cmp++; if (got_w.size() != 3) begin bad++; $display("FAIL imm_count: got %0d want 3", got_w.size()); end
    else begin
      cmp++; if (got_w[0] !== 32'h0C04_0010 || got_a[0] !== 32'h0) begin bad++; $display("FAIL addi: got %h@%h want 0c040010@0", got_w[0], got_a[0]); end
      cmp++; if (got_w[1] !== 32'h2422_FFFE || got_a[1] !== 32'h4) begin bad++; $display("FAIL beq: got %h@%h want 2422fffe@4", got_w[1], got_a[1]); end
    end
  endtask

  task automatic test_illegal;
    prog.delete();
    prog.push_back('{1, 1, 2, 3, 0});
    prog.push_back('{13, 7, 7, 7, 7});
    prog.push_back('{1, 4, 5, 6, 0});
    prog.push_back('{12, 0, 0, 0, 0});
    run_prog();
    cmp++; if (got_w.size() != 3) begin bad++; $display("FAIL illegal_count: got %0d want 3", got_w.size()); end
    else begin
      cmp++; if (got_w[1] !== 32'h0485_3000 || got_a[1] !== 32'h4) begin bad++; $display("FAIL illegal_next: got %h@%h want 04853000@4", got_w[1], got_a[1]); end
    end
    cmp++; if (err_opcode !== 1'b1) begin bad++; $display("FAIL err_opcode_set: got %b want 1", err_opcode); end
    pulse_start();
    cmp++; if (err_opcode !== 1'b0 || done !== 1'b0 || word_count !== 9'd0) begin bad++; $display("FAIL start_clear: got eo=%b d=%b wc=%0d want 0,0,0", err_opcode, done, word_count); end
    send('{12, 0, 0, 0, 0});
  endtask

  task automatic test_full;
    pulse_start();
    clear_q();
    for (int i = 0; i < 4; i++) send('{1, 1, 2, i + 1, 0});
    cmp++; if (d4_mem_we !== 1'b1 || d4_mem_addr !== 32'hC || d4_mem_wdata !== 32'h3000_0000) begin bad++; $display("FAIL full_write: got we=%b %h@%h want 1 30000000@c", d4_mem_we, d4_mem_wdata, d4_mem_addr); end
    cmp++; if (d4_err_full !== 1'b1) begin bad++; $display("FAIL err_full: got %b want 1", d4_err_full); end
    @(negedge clk);
    cmp++; if (d4_done !== 1'b1 || d4_in_ready !== 1'b0) begin bad++; $display("FAIL full_done: got done=%b rdy=%b want 1,0", d4_done, d4_in_ready); end
    cmp++; if (d4_word_count !== 9'd4 || got4_w.size() != 4) begin bad++; $display("FAIL full_count: got %0d/%0d want 4/4", d4_word_count, got4_w.size()); end
    cmp++; if (err_full !== 1'b0) begin bad++; $display("FAIL deep_no_full: got %b want 0", err_full); end
    send('{12, 0, 0, 0, 0});
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++) begin
      prog.delete();
      for (int n = $urandom_range(12, 1); n > 0; n--) begin
        int op = $urandom_range(15, 0);
        prog.push_back('{op == 12 ? 1 : op, $urandom_range(31, 0), $urandom_range(31, 0),
                         $urandom_range(31, 0), $urandom_range(16'hFFFF, 0)});
      end
      prog.push_back('{12, 0, 0, 0, 0});
      run_prog();
      model(64);
      cmp++; if (got_w.size() != m_w.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", k, got_w.size(), m_w.size()); end
      else foreach (m_w[i]) begin
        cmp++; if (got_w[i] !== m_w[i] || got_a[i] !== m_a[i]) begin bad++; $display("FAIL rnd%0d_w%0d: got %h@%h want %h@%h", k, i, got_w[i], got_a[i], m_w[i], m_a[i]); end
      end
      cmp++; if ({err_opcode, err_full, done} !== {m_eo, m_ef, 1'b1} || word_count !== 9'(m_cnt)) begin bad++; $display("FAIL rnd%0d_flags: got eo=%b ef=%b d=%b wc=%0d want %b %b 1 %0d", k, err_opcode, err_full, done, word_count, m_eo, m_ef, m_cnt); end
`ifdef ENCODER_CHECKSUM_EN
      cmp++; if (checksum !== m_chk) begin bad++; $display("FAIL rnd%0d_chk: got %h want %h", k, checksum, m_chk); end
`endif
      model(4);
      cmp++; if (got4_w.size() != m_w.size()) begin bad++; $display("FAIL rnd4_%0d_count: got %0d want %0d", k, got4_w.size(), m_w.size()); end
      else foreach (m_w[i]) begin
        cmp++; if (got4_w[i] !== m_w[i] || got4_a[i] !== m_a[i]) begin bad++; $display("FAIL rnd4_%0d_w%0d: got %h@%h want %h@%h", k, i, got4_w[i], got4_a[i], m_w[i], m_a[i]); end
      end
      cmp++; if ({d4_err_opcode, d4_err_full, d4_done} !== {m_eo, m_ef, 1'b1} || d4_word_count !== 9'(m_cnt)) begin bad++; $display("FAIL rnd4_%0d_flags: got eo=%b ef=%b d=%b wc=%0d want %b %b 1 %0d", k, d4_err_opcode, d4_err_full, d4_done, d4_word_count, m_eo, m_ef, m_cnt); end
    end
  endtask

`ifdef ENCODER_CHECKSUM_EN
  task automatic test_checksum;
    prog.delete();
    prog.push_back('{1, 1, 2, 3, 0});
    prog.push_back('{12, 0, 0, 0, 0});
    run_prog();
    cmp++; if (checksum !== 32'h3422_1800) begin bad++; $display("FAIL checksum: got %h want 34221800", checksum); end
  endtask
`endif

  task automatic test_reset_mid_load;
    pulse_start();
    send('{1, 1, 2, 3, 0});
    in_opcode = 6'd1; in_rs = 5'd2; in_rt = 5'd3; in_rd = 5'd4; in_valid = 1;
    @(posedge clk);
    #2 reset = 0;
    #1;
    cmp++; if ({in_ready, mem_we, done, err_opcode, err_full} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_count !== 9'd0) begin bad++; $display("FAIL mid_reset: got rdy=%b we=%b addr=%h data=%h wc=%0d want all 0", in_ready, mem_we, mem_addr, mem_wdata, word_count); end
    clear_q();
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    cmp++; if (got_a.size() != 0 || in_ready !== 1'b0) begin bad++; $display("FAIL post_reset_writes: got %0d writes rdy=%b want 0,0", got_a.size(), in_ready); end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_illegal();
    test_full();
    test_random();
`ifdef ENCODER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
